// File: rtl/prng_pkg.sv
// Shared constants and serializer state type for the PRNG word serializer.
package prng_pkg;
  localparam int PRNG_W = 128;
  localparam int DROP_W = 16;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SERVE = 1'b1
  } ser_state_t;
endpackage

// File: rtl/prng_sync_fifo.sv
// Single-clock word FIFO with head read-through, registered count and a
// synchronous flush that overrides push and pop.
module prng_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_count <= r_count + {{(CW-1){1'b0}}, i_push} - {{(CW-1){1'b0}}, i_pop};
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/prng_word_serializer.sv
// Buffers qualified 128-bit PRNG words and streams them as OUT_W-bit slices.
// Repetition health test is built only when PRNG_HEALTH_TEST_EN is defined.
module prng_word_serializer
  import prng_pkg::*;
#(
  parameter int OUT_W     = 32,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PRNG_W-1:0]      prng_in,
  input  logic                   in_valid,
  input  logic                   clear_fail,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   health_fail,
  output logic [DROP_W-1:0]      drop_cnt
);
  localparam int N  = PRNG_W / OUT_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  ser_state_t                r_state;
  logic [N-1:0][OUT_W-1:0]   r_hold;
  logic [IW-1:0]             r_idx;
  logic [OUT_W-1:0]          r_out_data;
  logic                      r_out_valid;
  logic [DROP_W-1:0]         r_drop_cnt;

  logic [CW-1:0]             w_count;
  logic [PRNG_W-1:0]         w_head;
  logic [IW-1:0]             w_next_idx;
  logic                      w_push, w_pop, w_reject, w_full, w_hs;
  logic                      w_trip, w_hf, w_block;

`ifdef PRNG_HEALTH_TEST_EN
  localparam int RW = $clog2(REP_LIMIT + 1);

  logic [PRNG_W-1:0] r_prev;
  logic              r_prev_vld;
  logic [RW-1:0]     r_rep_cnt;
  logic              r_health_fail;
  logic              w_match;
  logic [RW-1:0]     w_rep_next;

  // Repetition count of the incoming sample; saturates at the trip level
  always_comb begin
    w_match = r_prev_vld && (prng_in == r_prev);
    if (!w_match) begin
      w_rep_next = RW'(1);
    end else if (r_rep_cnt == RW'(REP_LIMIT)) begin
      w_rep_next = r_rep_cnt;
    end else begin
      w_rep_next = r_rep_cnt + RW'(1);
    end
    w_trip = in_valid && !clear_fail && (w_rep_next == RW'(REP_LIMIT));
  end

  // clear_fail wins over a same-cycle sample, which is neither compared nor kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev        <= {PRNG_W{1'b0}};
      r_prev_vld    <= 1'b0;
      r_rep_cnt     <= {RW{1'b0}};
      r_health_fail <= 1'b0;
    end else if (clear_fail) begin
      r_prev_vld    <= 1'b0;
      r_rep_cnt     <= {RW{1'b0}};
      r_health_fail <= 1'b0;
    end else if (in_valid) begin
      r_prev     <= prng_in;
      r_prev_vld <= 1'b1;
      r_rep_cnt  <= w_rep_next;
      if (w_trip) begin
        r_health_fail <= 1'b1;
      end
    end
  end

  assign w_hf    = r_health_fail;
  assign w_block = clear_fail;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_fail;
  assign w_trip         = 1'b0;
  assign w_hf           = 1'b0;
  assign w_block        = 1'b0;
`endif

  assign w_full     = (w_count >= CW'(DEPTH));
  assign w_push     = in_valid && !w_full && !w_hf && !w_block && !w_trip;
  assign w_reject   = in_valid && !w_push;
  assign w_hs       = r_out_valid && out_ready;
  assign w_next_idx = r_idx + {{(IW-1){1'b0}}, 1'b1};

  // Head is taken when idle, or when the last slice of the held word is accepted
  always_comb begin
    w_pop = 1'b0;
    if (w_trip) begin
      w_pop = 1'b0;
    end else if (r_state == EMPTY) begin
      w_pop = (w_count != {CW{1'b0}});
    end else if (w_hs && (r_idx == LAST_IDX)) begin
      w_pop = (w_count != {CW{1'b0}});
    end else begin
      w_pop = 1'b0;
    end
  end

  prng_sync_fifo #(
    .WIDTH (PRNG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (prng_in),
    .i_pop   (w_pop),
    .i_flush (w_trip),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  // Serializer FSM; a health trip aborts the current word immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_trip) begin
      r_state     <= EMPTY;
      r_hold      <= {PRNG_W{1'b0}};
      r_idx       <= {IW{1'b0}};
      r_out_data  <= {OUT_W{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_pop) begin
            r_hold      <= w_head;
            r_idx       <= {IW{1'b0}};
            r_out_data  <= w_head[OUT_W-1:0];
            r_out_valid <= 1'b1;
            r_state     <= SERVE;
          end
        end
        SERVE: begin
          if (w_hs) begin
            if (r_idx != LAST_IDX) begin
              r_idx      <= w_next_idx;
              r_out_data <= r_hold[w_next_idx];
            end else if (w_pop) begin
              r_hold     <= w_head;
              r_idx      <= {IW{1'b0}};
              r_out_data <= w_head[OUT_W-1:0];
            end else begin
              r_idx       <= {IW{1'b0}};
              r_out_valid <= 1'b0;
              r_state     <= EMPTY;
            end
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_idx       <= {IW{1'b0}};
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating reject counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= {DROP_W{1'b0}};
    end else if (w_reject && (r_drop_cnt != {DROP_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign fifo_count  = w_count;
  assign health_fail = w_hf;
  assign drop_cnt    = r_drop_cnt;
endmodule
